fc_argmax_reader: RTL and testbench
===================================

FC_ARGMAX_READER -- requirements
Module: fc_argmax_reader

Interface
REQ-001 Parameters SHALL be:
- IN_SIZE, default 10, number of W-bit elements in the input vector.
- W, default 8, element width, signed two's complement.
- IDX_W, default 4, class index width, with 2**IDX_W >= IN_SIZE.

REQ-002 Ports SHALL be:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  level "vector ready"; driven by the FC layer's done.
- vec_flat  input  W*IN_SIZE  signed; element k at bits [k*W +: W].
- out_ready  input  1  consumer accepts the result.
- out_valid  output  1  result held valid.
- class_idx  output  IDX_W  index of the maximum element.
- max_score  output  W  signed value of the maximum element; present only with FC_ARGMAX_SCORE_EN.
- busy  output  1  high in SCAN or HOLD.

REQ-003 One clock domain SHALL be used; reset SHALL be synchronous and active-high on port reset.

Function
REQ-004 States SHALL be IDLE, SCAN and HOLD, encoded in 2 bits.
REQ-005 A registered copy in_valid_d SHALL be updated every clock edge in all states; a capture event is in_valid=1 with in_valid_d=0.
REQ-006 IDLE + capture event at edge T:
- latch vec_flat into an internal buffer;
- set best_val = element 0, best_idx = 0, cnt = 1;
- go to SCAN, or go to HOLD if IN_SIZE = 1.
REQ-007 SCAN, one element per edge: if buf[cnt] > best_val (signed, strictly greater), load best_val and best_idx = cnt; then increment cnt.
REQ-008 SCAN SHALL exit to HOLD on the edge that processes element IN_SIZE-1, setting out_valid = 1 and driving class_idx/max_score from the final best values.
REQ-009 Latency: out_valid SHALL be high exactly IN_SIZE-1 edges after capture edge T (9 for default).
REQ-010 Ties SHALL resolve to the lowest index.
REQ-011 HOLD: out_valid, class_idx and max_score SHALL stay stable until an edge with out_ready=1; that edge clears out_valid and returns to IDLE.
REQ-012 out_ready SHALL be ignored in IDLE and SCAN.
REQ-013 Capture events during SCAN or HOLD SHALL be ignored and SHALL NOT be queued.
REQ-014 The latched buffer SHALL NOT change during SCAN, even if vec_flat changes.
REQ-015 in_valid held high across the return to IDLE SHALL NOT trigger a new capture; a fresh 0->1 transition is required.
REQ-016 busy SHALL be 1 exactly when the state is SCAN or HOLD.
REQ-017 A capture and an out_ready on the same edge in HOLD SHALL only retire the current result; no capture occurs.

Reset
REQ-018 On a reset edge, regardless of state, the block SHALL set:
- state = IDLE;
- out_valid = 0, busy = 0, class_idx = 0, max_score = 0;
- cnt = 0, best values = 0, in_valid_d = 0.
REQ-019 Reset mid-SCAN or mid-HOLD SHALL discard the result with no out_valid pulse.
REQ-020 If in_valid is 1 on the first edge after reset deasserts, that edge SHALL be a capture event.

Configuration
REQ-021 Macro FC_ARGMAX_SCORE_EN defined:
- port max_score and its register SHALL exist;
- max_score behaves per REQ-008/011/018.
REQ-022 Macro FC_ARGMAX_SCORE_EN undefined:
- port max_score and its register SHALL be absent;
- best_val remains internal;
- all other behaviour is identical.

Verification
REQ-023 Basic argmax: vector {3,9,1,0,7,2,0,0,5,4} with an in_valid rise -> out_valid after 9 edges, class_idx=1, max_score=9.
REQ-024 Tie-break: {5,0,5,5,0,0,0,0,0,5} -> class_idx=0, max_score=5.
REQ-025 Signed compare: all elements -1 (0xFF) except element 7 = -128 -> class_idx=0, max_score=-1.
REQ-026 Backpressure and level input:
- out_ready held 0 for 20 cycles -> outputs stable, busy=1;
- out_ready=1 -> out_valid falls next edge;
- in_valid kept high -> no recapture.
REQ-027 Mid-scan events:
- in_valid toggles 0->1 and vec_flat changes at scan edge 4 -> result reflects the original vector;
- reset at scan edge 4 -> outputs 0, no out_valid, next in_valid rise scans normally.
REQ-028 Max last: element 9 = 127, others 0 -> class_idx=9; rebuild without FC_ARGMAX_SCORE_EN -> same class_idx and latency.

Source files
------------

// File: rtl/fc_argmax_reader_if.sv
// Handshake bundle between an FC layer, the argmax reader and its result consumer.
// Optional max_score lane is present only when FC_ARGMAX_SCORE_EN is defined.
interface fc_argmax_reader_if #(
  parameter int IN_SIZE = 10,
  parameter int W       = 8,
  parameter int IDX_W   = 4
);
  logic                   in_valid;
  logic [W*IN_SIZE-1:0]   vec_flat;
  logic                   out_ready;
  logic                   out_valid;
  logic [IDX_W-1:0]       class_idx;
`ifdef FC_ARGMAX_SCORE_EN
  logic [W-1:0]           max_score;
`endif
  logic                   busy;

  modport master (
    output in_valid, vec_flat, out_ready,
    input  out_valid, class_idx,
`ifdef FC_ARGMAX_SCORE_EN
    input  max_score,
`endif
    input  busy
  );

  modport slave (
    input  in_valid, vec_flat, out_ready,
    output out_valid, class_idx,
`ifdef FC_ARGMAX_SCORE_EN
    output max_score,
`endif
    output busy
  );
endinterface

// File: rtl/fc_argmax_reader.sv
// Sequential argmax over a latched FC output vector, one element per clock, result held until consumed.
// Optional feature macro: FC_ARGMAX_SCORE_EN adds the max_score output and its register.
module fc_argmax_reader #(
  parameter int IN_SIZE = 10,
  parameter int W       = 8,
  parameter int IDX_W   = 4
) (
  input logic               clk,
  input logic               reset,
  fc_argmax_reader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    in_valid_d_q, in_valid_d_d;
  logic [W*IN_SIZE-1:0]    vec_buf_q, vec_buf_d;
  logic signed [W-1:0]     best_val_q, best_val_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [IDX_W-1:0]        class_idx_q, class_idx_d;
`ifdef FC_ARGMAX_SCORE_EN
  logic signed [W-1:0]     max_score_q, max_score_d;
`endif

  logic                    capture;
  logic                    last_elem;
  logic signed [W-1:0]     cur_elem;
  logic signed [W-1:0]     next_val;
  logic [IDX_W-1:0]        next_idx;

  assign capture   = bus.in_valid && !in_valid_d_q;
  assign last_elem = (cnt_q == IDX_W'(IN_SIZE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (capture) state_d = (IN_SIZE == 1) ? HOLD : SCAN;
      SCAN: if (last_elem) state_d = HOLD;
      HOLD: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Running comparison: strict greater-than keeps the earliest index on ties.
  always_comb begin
    cur_elem = vec_buf_q[cnt_q*W +: W];
    next_val = best_val_q;
    next_idx = best_idx_q;
    if (cur_elem > best_val_q) begin
      next_val = cur_elem;
      next_idx = cnt_q;
    end
  end

  always_comb begin
    in_valid_d_d = bus.in_valid;
    vec_buf_d    = vec_buf_q;
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    class_idx_d  = class_idx_q;
`ifdef FC_ARGMAX_SCORE_EN
    max_score_d  = max_score_q;
`endif
    case (state_q)
      IDLE: begin
        if (capture) begin
          vec_buf_d  = bus.vec_flat;
          best_val_d = bus.vec_flat[W-1:0];
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
          if (IN_SIZE == 1) begin
            out_valid_d = 1'b1;
            class_idx_d = '0;
`ifdef FC_ARGMAX_SCORE_EN
            max_score_d = bus.vec_flat[W-1:0];
`endif
          end
        end
      end
      SCAN: begin
        best_val_d = next_val;
        best_idx_d = next_idx;
        cnt_d      = cnt_q + 1'b1;
        if (last_elem) begin
          out_valid_d = 1'b1;
          class_idx_d = next_idx;
`ifdef FC_ARGMAX_SCORE_EN
          max_score_d = next_val;
`endif
        end
      end
      HOLD: begin
        if (bus.out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_valid_d_q <= 1'b0;
      vec_buf_q    <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      class_idx_q  <= '0;
`ifdef FC_ARGMAX_SCORE_EN
      max_score_q  <= '0;
`endif
    end else begin
      in_valid_d_q <= in_valid_d_d;
      vec_buf_q    <= vec_buf_d;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      class_idx_q  <= class_idx_d;
`ifdef FC_ARGMAX_SCORE_EN
      max_score_q  <= max_score_d;
`endif
    end
  end

  always_comb begin
    bus.out_valid = out_valid_q;
    bus.class_idx = class_idx_q;
    bus.busy      = (state_q != IDLE);
`ifdef FC_ARGMAX_SCORE_EN
    bus.max_score = max_score_q;
`endif
  end

endmodule

// File: tb/tb_fc_argmax_reader.sv
// Self-checking bench for fc_argmax_reader: directed corner vectors plus random vectors against an argmax model.
// max_score is checked only when FC_ARGMAX_SCORE_EN is defined.
module tb_fc_argmax_reader;
  localparam int IN_SIZE = 10;
  localparam int W       = 8;
  localparam int IDX_W   = 4;

  logic clk;
  logic reset;
  int   vector_count;
  int   miss_count;
  int   vec_elems [IN_SIZE];

  fc_argmax_reader_if #(.IN_SIZE(IN_SIZE), .W(W), .IDX_W(IDX_W)) bus ();

  fc_argmax_reader #(.IN_SIZE(IN_SIZE), .W(W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vector_count++;
    if (observed != expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [W*IN_SIZE-1:0] pack_vec();
    logic [W*IN_SIZE-1:0] flat;
    flat = '0;
    for (int i = 0; i < IN_SIZE; i++) flat[i*W +: W] = W'(vec_elems[i]);
    return flat;
  endfunction

  // Reference: first index holding the largest signed value.
  function automatic int model_argmax();
    int best;
    best = 0;
    for (int i = 1; i < IN_SIZE; i++)
      if (vec_elems[i] > vec_elems[best]) best = i;
    return best;
  endfunction

  task automatic check_score(input string tag, input int expected);
`ifdef FC_ARGMAX_SCORE_EN
    checkOutput(tag, int'($signed(bus.max_score)), expected);
`else
    if (expected > 1000) $display("[TB] %s unreachable", tag);
`endif
  endtask

  task automatic capture_vec();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.vec_flat = pack_vec();
    bus.in_valid = 1'b1;
    @(negedge clk);
  endtask

  // keep_high: in_valid stays high throughout; glitch: in_valid re-rises mid-scan with a new vector.
  task automatic applyStimulus(input int hold_cycles, input bit keep_high, input bit glitch);
    int exp_idx, exp_val, k;
    exp_idx = model_argmax();
    exp_val = vec_elems[exp_idx];
    capture_vec();
    checkOutput("busy_after_capture", int'(bus.busy), 1);
    if (!keep_high) bus.in_valid = 1'b0;
    k = 1;
    while (!bus.out_valid && k < 40) begin
      if (glitch && k == 3) begin
        bus.in_valid = 1'b1;
        bus.vec_flat = ~bus.vec_flat;
      end
      @(negedge clk);
      k++;
    end
    checkOutput("latency", k - 1, IN_SIZE - 1);
    checkOutput("class_idx", int'(bus.class_idx), exp_idx);
    check_score("max_score", exp_val);
    for (int c = 0; c < hold_cycles; c++) begin
      @(negedge clk);
      checkOutput("hold_valid", int'(bus.out_valid), 1);
      checkOutput("hold_idx", int'(bus.class_idx), exp_idx);
      check_score("hold_score", exp_val);
    end
    checkOutput("hold_busy", int'(bus.busy), 1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("retire_valid", int'(bus.out_valid), 0);
    checkOutput("retire_busy", int'(bus.busy), 0);
    repeat (12) @(negedge clk);
    checkOutput("no_recapture", int'(bus.busy), 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < IN_SIZE; i++) vec_elems[i] = v;
  endtask

  initial begin
    vector_count  = 0;
    miss_count    = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.vec_flat  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", int'(bus.out_valid), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_idx", int'(bus.class_idx), 0);
    check_score("rst_score", 0);
    reset = 1'b0;

    vec_elems = '{3, 9, 1, 0, 7, 2, 0, 0, 5, 4};
    applyStimulus(2, 1'b0, 1'b0);
    vec_elems = '{5, 0, 5, 5, 0, 0, 0, 0, 0, 5};
    applyStimulus(1, 1'b0, 1'b0);
    set_all(-1);
    vec_elems[7] = -128;
    applyStimulus(1, 1'b0, 1'b0);
    set_all(0);
    vec_elems[9] = 127;
    applyStimulus(20, 1'b1, 1'b0);
    vec_elems = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    applyStimulus(1, 1'b0, 1'b1);

    // Reset four edges into a scan discards the result entirely.
    vec_elems = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 50};
    capture_vec();
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_idx", int'(bus.class_idx), 0);
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      checkOutput("midrst_no_pulse", seen, 0);
    end
    vec_elems = '{-3, -7, 12, 12, -128, 0, 11, 12, 1, 2};
    applyStimulus(1, 1'b0, 1'b0);

    // in_valid high on the first edge after reset is a capture.
    for (int i = 0; i < IN_SIZE; i++) vec_elems[i] = i * 3 - 10;
    vec_elems[4] = 100;
    bus.vec_flat = pack_vec();
    bus.in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_capture", int'(bus.busy), 1);
    bus.in_valid = 1'b0;
    begin
      int k;
      k = 1;
      while (!bus.out_valid && k < 40) begin
        @(negedge clk);
        k++;
      end
      checkOutput("post_rst_latency", k - 1, IN_SIZE - 1);
      checkOutput("post_rst_idx", int'(bus.class_idx), 4);
      check_score("post_rst_score", 100);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput("post_rst_retire", int'(bus.out_valid), 0);
    end

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < IN_SIZE; i++) begin
        if (r % 3 == 0) vec_elems[i] = int'($urandom_range(0, 3)) - 2;
        else vec_elems[i] = int'($urandom_range(0, 255)) - 128;
      end
      applyStimulus(int'($urandom_range(0, 3)), 1'(r % 4 == 1), 1'(r % 5 == 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end
endmodule
